// File: rtl/wave_synth.sv
// wave_synth: divider-clocked 8-bit phase tone generator with square/saw/triangle/sine shaping and 256-clock PWM output.
// Optional macro SYNTH_SINE_EN builds a quarter-wave sine ROM for mode 11; otherwise mode 11 repeats the triangle.
module wave_synth (
    input  logic        clk,
    input  logic        nrst,
    input  logic [17:0] divider,
    input  logic [1:0]  mode,
    input  logic        strobe,
    output logic [7:0]  sample,
    output logic        pwm_out
);
    logic        gate_q;
    logic [17:0] div_q, tick_cnt;
    logic [1:0]  mode_q;
    logic [7:0]  phase, pwm_cnt, tri_s, wave_s, shaped;
    logic        step, wrap;

    assign step = tick_cnt == div_q - 18'd1;
    assign wrap = step && phase == 8'hff;
    assign tri_s = phase[7] ? {~phase[6:0], 1'b1} : {phase[6:0], 1'b0};

`ifdef SYNTH_SINE_EN
    localparam logic [6:0] sine_rom [64] = '{
          0,   3,   6,   9,  12,  16,  19,  22,  25,  28,  31,  34,  37,  40,  43,  46,
         49,  51,  54,  57,  60,  63,  65,  68,  71,  73,  76,  78,  81,  83,  85,  88,
         90,  92,  94,  96,  98, 100, 102, 104, 106, 107, 109, 111, 112, 113, 115, 116,
        117, 118, 120, 121, 122, 122, 123, 124, 125, 125, 126, 126, 126, 127, 127, 127
    };
    logic [5:0] q;
    logic [6:0] mag;
    // The falling quarter reads the table backwards; its q=0 point is the peak, which lies just past the table.
    assign q = phase[5:0];
    assign mag = phase[6] ? (q == 6'd0 ? 7'd127 : sine_rom[6'd0 - q]) : sine_rom[q];
    assign wave_s = phase[7] ? 8'd128 - {1'b0, mag} : 8'd128 + {1'b0, mag};
`else
    assign wave_s = tri_s;
`endif

    assign shaped = (!gate_q || div_q == 18'd0) ? 8'd0 :
                    mode_q == 2'd0 ? {8{~phase[7]}} :
                    mode_q == 2'd1 ? phase :
                    mode_q == 2'd2 ? tri_s : wave_s;

    // Note state: latch settings at onset and at phase wrap, step phase every div_q clocks while held.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            gate_q   <= 1'b0;
            div_q    <= '0;
            mode_q   <= '0;
            tick_cnt <= '0;
            phase    <= '0;
        end else begin
            gate_q <= strobe;
            if (strobe && !gate_q) begin
                div_q    <= divider;
                mode_q   <= mode;
                tick_cnt <= '0;
                phase    <= '0;
            end else if (strobe && div_q != 18'd0) begin
                tick_cnt <= step ? 18'd0 : tick_cnt + 18'd1;
                if (step) phase <= phase + 8'd1;
                if (wrap) begin
                    div_q  <= divider;
                    mode_q <= mode;
                end
            end else begin
                tick_cnt <= '0;
                phase    <= '0;
            end
        end
    end

    // Output stage: register the shaped sample, then compare it against the free-running PWM frame counter.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sample  <= '0;
            pwm_out <= 1'b0;
            pwm_cnt <= '0;
        end else begin
            sample  <= shaped;
            pwm_out <= sample > pwm_cnt;
            pwm_cnt <= pwm_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_wave_synth.sv
// tb_wave_synth: directed checks of wave_synth reset, waveforms, note changes, release, mute and PWM duty.
module tb_wave_synth;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [17:0] divider = 18'd5;
    logic [1:0]  mode = 2'd0;
    logic        strobe = 1'b1;
    logic [7:0]  sample;
    logic        pwm_out;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cnt;

    wave_synth dut (
        .clk(clk),
        .nrst(nrst),
        .divider(divider),
        .mode(mode),
        .strobe(strobe),
        .sample(sample),
        .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic onset(input logic [17:0] d, input logic [1:0] m);
        divider = d;
        mode = m;
        strobe = 1'b1;
        step(1);
    endtask

    task automatic end_note;
        strobe = 1'b0;
        step(2);
    endtask

    function automatic int tri_exp(input int k);
        return k < 128 ? 2 * k : 2 * (255 - k) + 1;
    endfunction

    initial begin
        // reset held with a note pending
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("rst_sample", {24'd0, sample}, 0);
            chk("rst_pwm", {31'd0, pwm_out}, 0);
        end
        nrst = 1'b1;
        step(1);
        chk("onset_edge_sample", {24'd0, sample}, 0);
        step(1);
        chk("onset_first_sample", {24'd0, sample}, 255);
        step(2);
        chk("onset_pwm_high", {31'd0, pwm_out}, 1);
        // asynchronous reset mid-note
        #2 nrst = 1'b0;
        #1;
        chk("async_rst_sample", {24'd0, sample}, 0);
        chk("async_rst_pwm", {31'd0, pwm_out}, 0);
        #1 nrst = 1'b1;
        end_note;
        // square, divider 2
        onset(18'd2, 2'd0);
        step(1);
        chk("sq_start", {24'd0, sample}, 255);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            step(1);
            cnt += int'(pwm_out);
        end
        chk("sq_pwm_255", cnt, 255);
        chk("sq_low_half", {24'd0, sample}, 0);
        step(255);
        chk("sq_low_end", {24'd0, sample}, 0);
        step(1);
        chk("sq_period", {24'd0, sample}, 255);
        // release timing
        strobe = 1'b0;
        step(1);
        chk("rel_edge", {24'd0, sample}, 255);
        step(1);
        chk("rel_sample", {24'd0, sample}, 0);
        step(1);
        chk("rel_pwm", {31'd0, pwm_out}, 0);
        // sawtooth, divider 1
        onset(18'd1, 2'd1);
        for (int k = 0; k < 256; k++) begin
            step(1);
            chk("saw", {24'd0, sample}, k);
        end
        step(1);
        chk("saw_wrap", {24'd0, sample}, 0);
        end_note;
        // triangle, divider 1
        onset(18'd1, 2'd2);
        for (int k = 0; k < 256; k++) begin
            step(1);
            chk("tri", {24'd0, sample}, tri_exp(k));
        end
        end_note;
        // mode 11
        onset(18'd1, 2'd3);
        for (int k = 0; k < 256; k++) begin
            step(1);
`ifdef SYNTH_SINE_EN
            if (k % 64 == 0)
                chk("sine", {24'd0, sample}, k == 64 ? 255 : k == 192 ? 1 : 128);
`else
            chk("mode3_tri", {24'd0, sample}, tri_exp(k));
`endif
        end
        end_note;
        // mid-note change applied at the wrap
        onset(18'd1, 2'd1);
        step(100);
        chk("mid_saw99", {24'd0, sample}, 99);
        divider = 18'd3;
        mode = 2'd0;
        step(100);
        chk("mid_saw199", {24'd0, sample}, 199);
        step(56);
        chk("mid_saw255", {24'd0, sample}, 255);
        step(1);
        chk("mid_sq_start", {24'd0, sample}, 255);
        step(383);
        chk("mid_sq_p127", {24'd0, sample}, 255);
        step(1);
        chk("mid_sq_p128", {24'd0, sample}, 0);
        end_note;
        // mute
        onset(18'd0, 2'd0);
        step(1);
        chk("mute_a", {24'd0, sample}, 0);
        step(50);
        chk("mute_b", {24'd0, sample}, 0);
        end_note;
        // PWM duty at sample 64
        onset(18'd300, 2'd1);
        step(19202);
        chk("pwm64_sample", {24'd0, sample}, 64);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            step(1);
            cnt += int'(pwm_out);
        end
        chk("pwm64_duty", cnt, 64);
        end_note;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
